// File: rtl/graphics_pkg.sv
// Shared VGA geometry, sprite config register map and motion FSM state type
// for the sprite motion controller.
package graphics_pkg;

    localparam int unsigned VGA_WIDTH_DEF  = 640;
    localparam int unsigned VGA_HEIGHT_DEF = 480;
    localparam int unsigned SPRITE_W_DEF   = 272;
    localparam int unsigned SPRITE_H_DEF   = 176;

    localparam logic [9:0] RESET_POS = 10'd128;

    localparam logic [2:0] CFG_X_SPEED = 3'd0;
    localparam logic [2:0] CFG_Y_SPEED = 3'd1;
    localparam logic [2:0] CFG_CTRL    = 3'd2;
    localparam logic [2:0] CFG_X_POS   = 3'd3;
    localparam logic [2:0] CFG_Y_POS   = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        CALC_X,
        CALC_Y,
        COMMIT
    } motion_state_t;

endpackage

// File: rtl/axis_bounce.sv
// Single-axis position step: staged-position clamp, or bounded move that
// pins to the edge and reverses direction on contact.
module axis_bounce #(
    parameter int unsigned MAX_POS = 368
) (
    input  logic [9:0] pos,
    input  logic [2:0] speed,
    input  logic       dir,
    input  logic       move_en,
    input  logic       staged_valid,
    input  logic [9:0] staged_pos,
    output logic [9:0] next_pos,
    output logic       next_dir
);

    localparam logic [10:0] MAX11 = 11'(MAX_POS);

    logic [10:0] pos11;
    logic [10:0] spd11;
    logic [10:0] sum11;
    logic [10:0] stg11;

    always_comb begin
        pos11    = {1'b0, pos};
        spd11    = {8'd0, speed};
        sum11    = pos11 + spd11;
        stg11    = {1'b0, staged_pos};
        next_pos = pos;
        next_dir = dir;
        // A zero speed must never hit the edge tests, otherwise it would flip.
        if (staged_valid) begin
            next_pos = (stg11 > MAX11) ? MAX11[9:0] : staged_pos;
        end else if (move_en && (speed != '0)) begin
            if (!dir) begin
                if (sum11 >= MAX11) begin
                    next_pos = MAX11[9:0];
                    next_dir = 1'b1;
                end else begin
                    next_pos = sum11[9:0];
                end
            end else begin
                if (pos11 <= spd11) begin
                    next_pos = '0;
                    next_dir = 1'b0;
                end else begin
                    next_pos = 10'(pos11 - spd11);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion: config registers, IDLE/CALC_X/CALC_Y/COMMIT update
// sequence, animation divider and overrun detection.
module sprite_motion_ctrl
    import graphics_pkg::*;
#(
    parameter int unsigned VGA_WIDTH     = VGA_WIDTH_DEF,
    parameter int unsigned VGA_HEIGHT    = VGA_HEIGHT_DEF,
    parameter int unsigned SPRITE_W      = SPRITE_W_DEF,
    parameter int unsigned SPRITE_H      = SPRITE_H_DEF,
    parameter int unsigned ANIM_DIV_BITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_addr,
    input  logic [9:0] cfg_data,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       anim_frame,
    output logic       update_done,
    output logic       overrun
);

    localparam int unsigned MAX_X = VGA_WIDTH - SPRITE_W;
    localparam int unsigned MAX_Y = VGA_HEIGHT - SPRITE_H;

    motion_state_t state, state_next;

    logic [2:0] x_speed, y_speed;
    logic       x_dir, y_dir;
    logic       pause, step;
    logic [9:0] staged_x, staged_y;
    logic       staged_x_vld, staged_y_vld;
    logic [9:0] pend_x, pend_y;
    logic       pend_x_dir, pend_y_dir;
    logic [9:0] calc_x, calc_y;
    logic       calc_x_dir, calc_y_dir;
    logic [ANIM_DIV_BITS:0] anim_cnt;
    logic       cfg_fire;
    logic       move_en;

    assign cfg_ready  = rst_n && (state == IDLE);
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign move_en    = !pause || step;
    assign anim_frame = anim_cnt[ANIM_DIV_BITS];

    axis_bounce #(.MAX_POS(MAX_X)) u_axis_x (
        .pos          (sprite_x),
        .speed        (x_speed),
        .dir          (x_dir),
        .move_en      (move_en),
        .staged_valid (staged_x_vld),
        .staged_pos   (staged_x),
        .next_pos     (calc_x),
        .next_dir     (calc_x_dir)
    );

    axis_bounce #(.MAX_POS(MAX_Y)) u_axis_y (
        .pos          (sprite_y),
        .speed        (y_speed),
        .dir          (y_dir),
        .move_en      (move_en),
        .staged_valid (staged_y_vld),
        .staged_pos   (staged_y),
        .next_pos     (calc_y),
        .next_dir     (calc_y_dir)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = CALC_X;
            CALC_X:  state_next = CALC_Y;
            CALC_Y:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sprite_x     <= RESET_POS;
            sprite_y     <= RESET_POS;
            x_speed      <= '0;
            y_speed      <= '0;
            x_dir        <= 1'b0;
            y_dir        <= 1'b0;
            pause        <= 1'b0;
            step         <= 1'b0;
            staged_x     <= '0;
            staged_y     <= '0;
            staged_x_vld <= 1'b0;
            staged_y_vld <= 1'b0;
            pend_x       <= '0;
            pend_y       <= '0;
            pend_x_dir   <= 1'b0;
            pend_y_dir   <= 1'b0;
            anim_cnt     <= '0;
            update_done  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state       <= state_next;
            update_done <= 1'b0;

            if (frame_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            // Writes only land in IDLE, so they never collide with the COMMIT updates below.
            if (cfg_fire) begin
                case (cfg_addr)
                    CFG_X_SPEED: begin
                        x_speed <= cfg_data[2:0];
                        x_dir   <= cfg_data[3];
                    end
                    CFG_Y_SPEED: begin
                        y_speed <= cfg_data[2:0];
                        y_dir   <= cfg_data[3];
                    end
                    CFG_CTRL: begin
                        pause <= cfg_data[0];
                        step  <= cfg_data[1];
                    end
                    CFG_X_POS: begin
                        staged_x     <= cfg_data;
                        staged_x_vld <= 1'b1;
                    end
                    CFG_Y_POS: begin
                        staged_y     <= cfg_data;
                        staged_y_vld <= 1'b1;
                    end
                    default: ;
                endcase
            end

            case (state)
                CALC_X: begin
                    pend_x     <= calc_x;
                    pend_x_dir <= calc_x_dir;
                end
                CALC_Y: begin
                    pend_y     <= calc_y;
                    pend_y_dir <= calc_y_dir;
                end
                COMMIT: begin
                    sprite_x     <= pend_x;
                    sprite_y     <= pend_y;
                    x_dir        <= pend_x_dir;
                    y_dir        <= pend_y_dir;
                    staged_x_vld <= 1'b0;
                    staged_y_vld <= 1'b0;
                    step         <= 1'b0;
                    update_done  <= 1'b1;
                    if (move_en) begin
                        anim_cnt <= anim_cnt + (ANIM_DIV_BITS + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: stimulus queues expected updates,
// a negedge monitor pops and compares them whenever update_done is seen.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_addr = '0;
    logic [9:0] cfg_data = '0;
    logic [9:0] sprite_x, sprite_y;
    logic       anim_frame, update_done, overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       a;
        int         due;
    } exp_t;

    exp_t exp_q[$];

    sprite_motion_ctrl #(
        .VGA_WIDTH     (640),
        .VGA_HEIGHT    (480),
        .SPRITE_W      (272),
        .SPRITE_H      (176),
        .ANIM_DIV_BITS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .anim_frame  (anim_frame),
        .update_done (update_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: scoreboard pops on update_done; outputs must hold otherwise.
    logic [9:0] prev_x, prev_y;
    logic       prev_a;
    logic       prev_rst = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (update_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: update_done high with nothing expected (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("upd_sprite_x", 32'(sprite_x), 32'(e.x));
                check("upd_sprite_y", 32'(sprite_y), 32'(e.y));
                check("upd_anim_frame", 32'(anim_frame), 32'(e.a));
                check("upd_latency_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (rst_n && prev_rst) begin
            check("outputs_hold", {11'd0, sprite_x, sprite_y, anim_frame},
                  {11'd0, prev_x, prev_y, prev_a});
        end
        prev_x   = sprite_x;
        prev_y   = sprite_y;
        prev_a   = anim_frame;
        prev_rst = rst_n;
    end

    task automatic cfg_write(input logic [2:0] a, input logic [9:0] d);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic frame(input logic [9:0] ex, input logic [9:0] ey, input logic ea);
        @(negedge clk);
        frame_start = 1'b1;
        exp_q.push_back('{ex, ey, ea, cyc + 4});
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cfg_ready_low", 32'(cfg_ready), 0);
        check("reset_sprite_x", 32'(sprite_x), 128);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_sprite_x", 32'(sprite_x), 128);
        check("post_reset_sprite_y", 32'(sprite_y), 128);
        check("post_reset_anim", 32'(anim_frame), 0);
        check("post_reset_update_done", 32'(update_done), 0);
        check("post_reset_overrun", 32'(overrun), 0);
        check("post_reset_cfg_ready", 32'(cfg_ready), 1);

        // Zero speeds: position unchanged, counter 1
        frame(10'd128, 10'd128, 1'b0);

        // X: speed 5 right, staged 365, bounce at 368 then back
        cfg_write(3'd0, 10'd5);
        cfg_write(3'd3, 10'd365);
        frame(10'd365, 10'd128, 1'b0);
        frame(10'd368, 10'd128, 1'b0);
        frame(10'd363, 10'd128, 1'b0);

        // Y: speed 7 up, staged 4, bounce at 0 then down
        cfg_write(3'd1, 10'd15);
        cfg_write(3'd4, 10'd4);
        frame(10'd358, 10'd4, 1'b0);
        frame(10'd353, 10'd0, 1'b0);
        frame(10'd348, 10'd7, 1'b0);

        // Staged X 1000 written together with frame_start: clamp to 368
        @(negedge clk);
        check("cfg_ready_before_write", 32'(cfg_ready), 1);
        frame_start = 1'b1;
        cfg_valid   = 1'b1;
        cfg_addr    = 3'd3;
        cfg_data    = 10'd1000;
        exp_q.push_back('{10'd368, 10'd14, 1'b0, cyc + 4});
        @(negedge clk);
        frame_start = 1'b0;
        cfg_valid   = 1'b0;
        check("busy_cfg_ready_0", 32'(cfg_ready), 0);
        @(negedge clk);
        check("busy_cfg_ready_1", 32'(cfg_ready), 0);
        @(negedge clk);
        check("busy_cfg_ready_2", 32'(cfg_ready), 0);
        @(negedge clk);
        check("busy_cfg_ready_done", 32'(cfg_ready), 1);
        @(negedge clk);

        // Pause freezes motion and anim
        cfg_write(3'd2, 10'd1);
        frame(10'd368, 10'd14, 1'b0);
        frame(10'd368, 10'd14, 1'b0);
        frame(10'd368, 10'd14, 1'b0);
        // Step while paused: exactly one move, then cleared
        cfg_write(3'd2, 10'd3);
        frame(10'd363, 10'd21, 1'b0);
        frame(10'd363, 10'd21, 1'b0);
        cfg_write(3'd2, 10'd0);

        // Step while unpaused: plain updates
        cfg_write(3'd2, 10'd2);
        frame(10'd358, 10'd28, 1'b0);
        frame(10'd353, 10'd35, 1'b0);

        // Back-to-back frame_start: second is ignored and raises overrun
        check("overrun_before", 32'(overrun), 0);
        @(negedge clk);
        frame_start = 1'b1;
        exp_q.push_back('{10'd348, 10'd42, 1'b0, cyc + 4});
        @(negedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
        check("overrun_set", 32'(overrun), 1);

        // Sixteenth unpaused update toggles anim_frame
        frame(10'd343, 10'd49, 1'b0);
        frame(10'd338, 10'd56, 1'b0);
        frame(10'd333, 10'd63, 1'b0);
        frame(10'd328, 10'd70, 1'b1);
        check("overrun_sticky", 32'(overrun), 1);

        // Reset mid-update: no COMMIT, everything back to reset values
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_cfg_ready", 32'(cfg_ready), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset_sprite_x", 32'(sprite_x), 128);
        check("midreset_sprite_y", 32'(sprite_y), 128);
        check("midreset_anim", 32'(anim_frame), 0);
        check("midreset_overrun", 32'(overrun), 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameter VGA_WIDTH, default 640: visible pixels per line.
REQ-002 SHALL have parameter VGA_HEIGHT, default 480: visible lines per frame.
REQ-003 SHALL have parameter SPRITE_W, default 272: scaled sprite width in pixels.
REQ-004 SHALL have parameter SPRITE_H, default 176: scaled sprite height in pixels.
REQ-005 SHALL have parameter ANIM_DIV_BITS, default 4: anim_frame toggles every 2**ANIM_DIV_BITS updates.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port frame_start, input, 1: one-cycle pulse from the timing generator at start of vertical blanking.
REQ-009 SHALL have port cfg_valid, input, 1: config write request.
REQ-010 SHALL have port cfg_ready, output, 1: config write accepted when cfg_valid and cfg_ready are both high.
REQ-011 SHALL have port cfg_addr, input, 3: register select.
REQ-012 SHALL have port cfg_data, input, 10: write data.
REQ-013 SHALL have port sprite_x, output, 10: sprite left edge.
REQ-014 SHALL have port sprite_y, output, 10: sprite top edge.
REQ-015 SHALL have port anim_frame, output, 1: bitmap frame select.
REQ-016 SHALL have port update_done, output, 1: one-cycle pulse when new outputs are valid.
REQ-017 SHALL have port overrun, output, 1: sticky flag, set when frame_start arrives while not IDLE.

Function
REQ-018 Registers SHALL be decoded from cfg_addr as follows.
- 0 = X speed: data[2:0] magnitude, data[3] direction (1 = left).
- 1 = Y speed: same layout as X (1 = up).
- 2 = control: bit0 pause, bit1 step.
- 3 = staged X position.
- 4 = staged Y position.
- 5..7 = accepted and ignored.
REQ-019 FSM states SHALL be IDLE, CALC_X, CALC_Y, COMMIT, with transitions:
- IDLE -> CALC_X on frame_start.
- CALC_X -> CALC_Y -> COMMIT -> IDLE unconditionally.
REQ-020 cfg_ready SHALL be high only in IDLE.
REQ-021 A write accepted in the same cycle as frame_start SHALL take effect in that update.
REQ-022 Latency: frame_start sampled at edge k SHALL update sprite_x, sprite_y and anim_frame at edge k+3, with update_done high for exactly the following cycle.
REQ-023 Outputs SHALL NOT change at any other time.
REQ-024 A staged position SHALL be clamped to MAX_X = VGA_WIDTH-SPRITE_W (368) and MAX_Y = VGA_HEIGHT-SPRITE_H (304), applied at the next COMMIT, then discarded; a staged position overrides motion for that axis in that update.
REQ-025 Forward motion SHALL follow: if pos+speed >= MAX, then pos = MAX and direction flips; else pos += speed.
REQ-026 Reverse motion SHALL follow: if pos <= speed, then pos = 0 and direction flips; else pos -= speed.
REQ-027 Speed 0 SHALL never flip direction.
REQ-028 All arithmetic SHALL be 11-bit unsigned to avoid wrap.
REQ-029 An anim counter of ANIM_DIV_BITS+1 bits SHALL increment per unpaused update and wrap; anim_frame = counter MSB.
REQ-030 Pause SHALL freeze motion and anim, but staged positions still apply.
REQ-031 Step while paused SHALL perform one full update, then self-clear at COMMIT.
REQ-032 Step while unpaused SHALL self-clear with no extra effect.
REQ-033 frame_start outside IDLE SHALL be ignored and SHALL set overrun.
REQ-034 overrun SHALL clear only on reset.

Reset
REQ-035 On rst_n low at a clk edge, the block SHALL reset to:
- State IDLE.
- sprite_x = 128, sprite_y = 128.
- Speeds and directions 0, control 0, anim counter 0.
- anim_frame 0, update_done 0, overrun 0.
- Staged positions invalid.
REQ-036 cfg_ready SHALL be 0 while rst_n is low.
REQ-037 Reset mid-update SHALL abort the update with no COMMIT.

Structure
REQ-038 graphics_pkg SHALL hold the VGA geometry constants, the cfg address constants and the FSM state type.
REQ-039 One sub-module, axis_bounce, SHALL implement the single-axis step, clamp and flip, and SHALL be instantiated for X and Y.

Verification
REQ-040 Reset, then frame_start -> at edge k+3 sprite_x = 128, sprite_y = 128, update_done one cycle, anim_frame 0.
REQ-041 X speed 5 right, position 365, one frame_start -> sprite_x = 368, X direction becomes left; next frame -> 363.
REQ-042 Y speed 7 up from position 4 -> sprite_y = 0, direction flips down; next frame -> 7.
REQ-043 cfg write of X position 1000 with frame_start in the same cycle -> sprite_x = 368 after that update; cfg_ready low for 3 cycles.
REQ-044 Pause = 1, 3 frame_starts -> outputs unchanged; step pulse -> exactly one move, and step reads back cleared.
REQ-045 frame_start pulses 1 cycle apart -> second pulse ignored, overrun = 1 until reset; 16 unpaused updates -> anim_frame toggles once.
